// File: rtl/arith_cmd_issuer.sv
// arith_cmd_issuer: buffers arithmetic commands in a FIFO, issues them one at a time
// to a multicycle arithmetic unit and returns tagged results with error codes.
module arith_cmd_issuer #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [1:0]  rsp_op,
   output logic [1:0]  rsp_err,
   output logic        au_start,
   output logic [1:0]  au_op,
   output logic [7:0]  au_a,
   output logic [7:0]  au_b,
   input  logic        au_done,
   input  logic [15:0] au_result,
   output logic        busy,
   output logic [7:0]  issued_cnt
);
   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
   state_t state, next_state;
   logic [1:0] op_mem [DEPTH];
   logic [7:0] a_mem [DEPTH];
   logic [7:0] b_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [7:0] timer;
   logic push, pop, timeout, finish;
   // ready comes from the registered count only, so a pop never frees a slot combinationally
   assign cmd_ready = count != (AW+1)'(DEPTH);
   assign push = cmd_valid && cmd_ready;
   assign pop = state == IDLE && count != '0;
   assign timeout = timer == 8'(TIMEOUT - 1);
   assign finish = state == WAIT && (au_done || timeout);
   assign busy = state != IDLE || count != '0;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = pop ? START : IDLE;
         START:   next_state = WAIT;
         WAIT:    next_state = finish ? RESP : WAIT;
         default: next_state = rsp_ready ? IDLE : RESP;
      endcase
   end
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr] <= cmd_op;
         a_mem[wr_ptr] <= cmd_a;
         b_mem[wr_ptr] <= cmd_b;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         timer <= '0;
         au_start <= 1'b0;
         au_op <= '0;
         au_a <= '0;
         au_b <= '0;
         rsp_valid <= 1'b0;
         rsp_result <= '0;
         rsp_op <= '0;
         rsp_err <= '0;
         issued_cnt <= '0;
      end else begin
         state <= next_state;
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         au_start <= pop;
         timer <= state == WAIT ? timer + 8'd1 : 8'd0;
         if (pop) begin
            au_op <= op_mem[rd_ptr];
            au_a <= a_mem[rd_ptr];
            au_b <= b_mem[rd_ptr];
         end
         // a done arriving on the timeout cycle still wins over the timeout
         if (finish) begin
            rsp_valid <= 1'b1;
            rsp_op <= au_op;
            rsp_result <= au_done ? au_result : 16'd0;
            rsp_err <= !au_done ? 2'b10 : (au_op == 2'b11 && au_b == 8'd0) ? 2'b01 : 2'b00;
         end
         if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            issued_cnt <= issued_cnt + 8'd1;
         end
      end
   end
endmodule

// File: doc/arith_cmd_issuer.md
Name: arith_cmd_issuer

Overview:
- Initiator side of the start/op/a/b -> done/result multicycle arithmetic handshake.
- Accepts arithmetic commands on a valid/ready port and buffers them in a small FIFO. Issues them one at a time to the multicycle arithmetic unit, holding operands stable until done, and returns tagged results with error codes on a valid/ready response port.
- Sits between the command source (sequencer/testbench/CPU glue) and the arithmetic unit.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
AW, 2, log2(DEPTH), FIFO pointer width
TIMEOUT, 15, max cycles in WAIT without au_done before timeout error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full, registered count only)
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  8  operand a
cmd_b  in  8  operand b
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_result  out  16  result from unit (0 on timeout)
rsp_op  out  2  op of this response
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
au_start  out  1  one-cycle start pulse to arithmetic unit
au_op  out  2  op to unit, held stable
au_a  out  8  operand a to unit, held stable
au_b  out  8  operand b to unit, held stable
au_done  in  1  done pulse from unit
au_result  in  16  result from unit
busy  out  1  state != IDLE or FIFO non-empty
issued_cnt  out  8  completed response handshakes, wraps 255->0

Behaviour:
- Reset (async, rst=1): FIFO empty (pointers/count 0), state IDLE. All outputs 0 except cmd_ready=1. Timer 0. Any in-flight command and pending response are discarded.
- FIFO: push on cmd_valid&&cmd_ready. Pop only in IDLE when non-empty. Simultaneous push+pop keeps count. When full, cmd_ready=0 even in a pop cycle (no combinational ready path). Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if non-empty, pop head into au_op/au_a/au_b, au_start<=1, go START.
- START: au_start=1 for exactly this one cycle; next edge au_start<=0, timer<=0, go WAIT.
- WAIT, au_done=1: rsp_result<=au_result, rsp_op<=au_op, rsp_valid<=1, go RESP. rsp_err<=01 if au_op==11 && au_b==0, else 00.
- WAIT, au_done=0: timer++. When timer reaches TIMEOUT: rsp_result<=0, rsp_err<=10, rsp_valid<=1, go RESP.
- RESP: rsp_valid and all rsp_* held stable until rsp_ready. On handshake: rsp_valid<=0, issued_cnt++, go IDLE.
- au_op/au_a/au_b change only on pop; they stay stable from start through done and beyond.
- au_done outside WAIT (late pulse after timeout) is ignored. A timeout does not block the next issue.
- Latency with the unit attached, ADD into empty FIFO in IDLE: push edge 0, au_start high cycle 1, au_done high cycle 5, rsp_valid high from edge 6.
- Minimum gap between successive au_start pulses is 7 cycles, which guarantees the unit's done has cleared before the next start.
- Responses return strictly in command order.
- Arithmetic is passed through: rsp_result is the unit's 16-bit value (sub underflow wraps in 16 bits; div by zero yields 0xFFFF plus err 01).

Test Plan:
- Unit attached, push ADD a=25 b=17, rsp_ready=1 -> rsp_valid rises at edge 6 after push; rsp_result=42, rsp_op=00, rsp_err=00; au_start high exactly 1 cycle; issued_cnt=1.
- Push DIV 200/0, then DIV 200/7 -> responses in order: 0xFFFF err 01, then 28 err 00; au_a/au_b stable from start through done for each.
- Hold rsp_ready=0 and offer 7 commands (MUL 12*12, SUB 5-9, ...) -> 5 accepted (1 in flight + 4 FIFO), cmd_ready=0 afterwards; rsp_valid held with result 144. Release rsp_ready -> 144, then 0xFFFC, then the rest in order; cmd_ready reasserts after the first pop.
- au_done tied 0, TIMEOUT=15, push ADD 1+1 -> rsp_valid after 15 WAIT cycles with result 0, err 10. An au_done pulse injected during RESP is ignored, and the next command issues normally.
- Assert rst during WAIT with 3 commands queued -> immediately all outputs 0, cmd_ready=1, busy=0. After release, push ADD 3+4 -> result 7, err 00.
- Complete 256 commands -> issued_cnt reads 255 after 255 handshakes and wraps to 0 on the 256th.
